// File: rtl/r200_fetch_queue_pkg.sv
// Shared constants and types for the r200 IF->ID fetch queue.
package r200_fetch_queue_pkg;

  localparam int          R200_XLEN   = 32;
  localparam logic [31:0] R200_NOP    = 32'h0000_0013;
  localparam int          R200_PC_INC = 4;

  // Encoded as {enq_fire, deq_fire} so the cast from the fire bits is direct.
  typedef enum logic [1:0] {
    FQ_IDLE = 2'b00,
    FQ_DEQ  = 2'b01,
    FQ_ENQ  = 2'b10,
    FQ_BOTH = 2'b11
  } fq_op_e;

endpackage

// File: rtl/r200_fq_mem.sv
// Fetch-queue storage: DEPTH entries, one synchronous write port, one asynchronous read port.
module r200_fq_mem #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [3*XLEN-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [3*XLEN-1:0]        rdata
);

  logic [3*XLEN-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; validity lives in the control logic.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/r200_fetch_queue.sv
// IF->ID instruction buffer holding {pc, pc+4, instrn}; a flush drops every buffered entry in one cycle.
module r200_fetch_queue
  import r200_fetch_queue_pkg::*;
#(
  parameter int              XLEN  = R200_XLEN,
  parameter int              DEPTH = 4,
  parameter logic [XLEN-1:0] NOP   = XLEN'(R200_NOP)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [XLEN-1:0]            enq_instrn,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_pcp4,
  output logic [XLEN-1:0]            deq_instrn,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              enq_fire, deq_fire;
  fq_op_e            op;
  logic [XLEN-1:0]   enq_pcp4;
  logic [3*XLEN-1:0] wdata, rdata;
  logic [XLEN-1:0]   head_pc, head_pcp4, head_instrn;

  // Full/empty come from the occupancy counter; pointers alone cannot tell them apart.
  assign enq_ready = (count_q != CW'(DEPTH));
  assign deq_valid = (count_q != '0) && !flush;

  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready;
  assign op       = fq_op_e'({enq_fire, deq_fire});

  assign enq_pcp4 = enq_pc + XLEN'(R200_PC_INC);
  assign wdata    = {enq_pc, enq_pcp4, enq_instrn};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (op)
        FQ_ENQ: begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
        end
        FQ_DEQ: begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - CW'(1);
        end
        FQ_BOTH: begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  r200_fq_mem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (enq_fire),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign {head_pc, head_pcp4, head_instrn} = rdata;

  // Gate the head so an empty or flushing queue presents a NOP and zero PCs.
  assign deq_pc     = deq_valid ? head_pc     : '0;
  assign deq_pcp4   = deq_valid ? head_pcp4   : '0;
  assign deq_instrn = deq_valid ? head_instrn : NOP;
  assign count      = count_q;

endmodule

// File: tb/tb_r200_fetch_queue.sv
// Bench for r200_fetch_queue: directed vectors on DEPTH=4, random traffic on DEPTH=2/4/8 against queue models.
module tb_r200_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic        deq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_instrn;

  logic [2:0]  dv;
  logic [2:0]  er;
  logic [31:0] dpc [3];
  logic [31:0] dp4 [3];
  logic [31:0] din [3];
  logic [3:0]  cnt [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 2 : 8);
    logic [$clog2(D+1)-1:0] c;
    logic                   v_o;
    logic                   r_o;
    logic [31:0]            p_o;
    logic [31:0]            p4_o;
    logic [31:0]            i_o;

    r200_fetch_queue #(
      .XLEN  (32),
      .DEPTH (D),
      .NOP   (32'h0000_0013)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .enq_valid  (enq_valid),
      .enq_ready  (r_o),
      .enq_pc     (enq_pc),
      .enq_instrn (enq_instrn),
      .deq_valid  (v_o),
      .deq_ready  (deq_ready),
      .deq_pc     (p_o),
      .deq_pcp4   (p4_o),
      .deq_instrn (i_o),
      .count      (c)
    );

    assign dv[g]  = v_o;
    assign er[g]  = r_o;
    assign dpc[g] = p_o;
    assign dp4[g] = p4_o;
    assign din[g] = i_o;
    assign cnt[g] = 4'(c);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic drive(input logic f, input logic ev, input logic dr, input logic [31:0] pc);
    flush      = f;
    enq_valid  = ev;
    deq_ready  = dr;
    enq_pc     = pc;
    enq_instrn = instr_of(pc);
  endtask

  // Checks instance 0 (DEPTH=4) against an expected head state.
  task automatic chk_head(input string tag, input int ecnt, input logic edv, input logic eer,
                          input logic [31:0] epc);
    chk({tag, " count"}, 32'(cnt[0]), 32'(ecnt));
    chk({tag, " deq_valid"}, 32'(dv[0]), 32'(edv));
    chk({tag, " enq_ready"}, 32'(er[0]), 32'(eer));
    if (edv) begin
      chk({tag, " deq_pc"}, dpc[0], epc);
      chk({tag, " deq_pcp4"}, dp4[0], epc + 32'd4);
      chk({tag, " deq_instrn"}, din[0], instr_of(epc));
    end else begin
      chk({tag, " deq_instrn"}, din[0], NOP);
    end
  endtask

  typedef struct {
    logic        fl;
    logic        ev;
    logic        dr;
    logic [31:0] pc;
    int          ecnt;
    logic        edv;
    logic        eer;
    logic [31:0] epc;
  } vec_t;

  vec_t vt [18];

  // Random-phase reference: one queue of {pc, instrn} per instance.
  logic [63:0] mq [3][$];
  int          dep [3] = '{4, 2, 8};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fill to full, refused 5th enq, drain in order; then flush and PC wrap.
    vt[0]  = '{1'b0, 1'b1, 1'b0, 32'h100,      0, 1'b0, 1'b1, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 32'h104,      1, 1'b1, 1'b1, 32'h100};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 32'h108,      2, 1'b1, 1'b1, 32'h100};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 32'h10C,      3, 1'b1, 1'b1, 32'h100};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 32'h110,      4, 1'b1, 1'b0, 32'h100};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 32'h0,        4, 1'b1, 1'b0, 32'h100};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 32'h0,        3, 1'b1, 1'b1, 32'h104};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,        2, 1'b1, 1'b1, 32'h108};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,        1, 1'b1, 1'b1, 32'h10C};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,        0, 1'b0, 1'b1, 32'h0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 32'h200,      0, 1'b0, 1'b1, 32'h0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 32'h204,      1, 1'b1, 1'b1, 32'h200};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h208,      2, 1'b1, 1'b1, 32'h200};
    vt[13] = '{1'b1, 1'b1, 1'b1, 32'h20C,      3, 1'b0, 1'b1, 32'h0};
    vt[14] = '{1'b0, 1'b0, 1'b1, 32'h0,        0, 1'b0, 1'b1, 32'h0};
    vt[15] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 0, 1'b0, 1'b1, 32'h0};
    vt[16] = '{1'b0, 1'b0, 1'b1, 32'h0,        1, 1'b1, 1'b1, 32'hFFFFFFFC};
    vt[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        0, 1'b0, 1'b1, 32'h0};

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    chk_head("reset", 0, 1'b0, 1'b1, 32'h0);
    chk("reset deq_pc", dpc[0], 32'h0);
    chk("reset deq_pcp4", dp4[0], 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].fl, vt[i].ev, vt[i].dr, vt[i].pc);
      #2;
      chk_head($sformatf("vec%0d", i), vt[i].ecnt, vt[i].edv, vt[i].eer, vt[i].epc);
      @(negedge clk);
    end

    // Streaming at steady occupancy 2 across several pointer wraps.
    drive(1'b0, 1'b1, 1'b0, 32'h300);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h304);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h308 + 32'(4 * i));
      #2;
      chk_head($sformatf("stream%0d", i), 2, 1'b1, 1'b1, 32'h300 + 32'(4 * i));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of traffic, observed without a clock edge.
    drive(1'b0, 1'b1, 1'b0, 32'h400);
    #1;
    rst = 1'b0;
    #1;
    chk_head("midreset", 0, 1'b0, 1'b1, 32'h0);
    chk("midreset count d2", 32'(cnt[1]), 32'h0);
    chk("midreset count d8", 32'(cnt[2]), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int g = 0; g < 3; g++) mq[g].delete();
    for (int n = 0; n < 10000; n++) begin
      int thr;
      thr = (n / 1000) % 3 == 0 ? 25 : ((n / 1000) % 3 == 1 ? 50 : 85);
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < thr, $urandom);
      #2;
      for (int g = 0; g < 3; g++) begin
        int   sz;
        logic edv;
        sz  = mq[g].size();
        edv = (sz > 0) && !flush;
        chk($sformatf("rnd%0d d%0d count", n, dep[g]), 32'(cnt[g]), 32'(sz));
        chk($sformatf("rnd%0d d%0d deq_valid", n, dep[g]), 32'(dv[g]), 32'(edv));
        chk($sformatf("rnd%0d d%0d enq_ready", n, dep[g]), 32'(er[g]), 32'(sz != dep[g]));
        if (edv) begin
          chk($sformatf("rnd%0d d%0d deq_pc", n, dep[g]), dpc[g], mq[g][0][63:32]);
          chk($sformatf("rnd%0d d%0d deq_pcp4", n, dep[g]), dp4[g], mq[g][0][63:32] + 32'd4);
          chk($sformatf("rnd%0d d%0d deq_instrn", n, dep[g]), din[g], mq[g][0][31:0]);
        end else begin
          chk($sformatf("rnd%0d d%0d deq_instrn", n, dep[g]), din[g], NOP);
        end
        if (flush) begin
          mq[g].delete();
        end else begin
          if (edv && deq_ready) void'(mq[g].pop_front());
          if (enq_valid && sz != dep[g]) mq[g].push_back({enq_pc, enq_instrn});
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
